// File: rtl/otp_ctrl_chk_sched_pkg.sv
// Shared types and constants for the OTP check scheduler: sparse FSM encoding,
// Galois LFSR tap masks and parameter legality helpers.
package otp_ctrl_chk_sched_pkg;

   // Pairwise Hamming distance >= 4 so that single or double bit flips land in an illegal code.
   typedef enum logic [6:0] {
      ResetSt = 7'b0001011,
      IdleSt  = 7'b0110110,
      WaitSt  = 7'b1010001,
      ErrorSt = 7'b1101100
   } state_e;

   function automatic bit cnt_width_legal(int unsigned w);
      return w inside {32, 40, 48, 64};
   endfunction

   // Right-shifting Galois feedback mask, bit (t-1) set for each tap t of a maximal-length polynomial.
   function automatic logic [63:0] lfsr_taps(int unsigned w);
      case (w)
         32:      return 64'h0000_0000_8020_0003;
         40:      return 64'h0000_00A0_0014_0000;
         48:      return 64'h0000_C000_0018_0000;
         64:      return 64'hD800_0000_0000_0000;
         default: return 64'h0;
      endcase
   endfunction

endpackage

// File: rtl/otp_ctrl_chk_lfsr.sv
// Period LFSR with usage-counted reseed request; a step and a reseed in the same cycle merge into one update.
// Entropy is non-blocking: the LFSR keeps stepping while the reseed request is pending.
module otp_ctrl_chk_lfsr
   import otp_ctrl_chk_sched_pkg::*;
#(
   parameter int unsigned         CntWidth           = 40,
   parameter int unsigned         EntropyWidth       = 32,
   parameter int unsigned         LfsrUsageThreshold = 16,
   parameter logic [CntWidth-1:0] LfsrSeed           = CntWidth'(1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    step_i,
   input  logic                    entropy_ack_i,
   input  logic [EntropyWidth-1:0] entropy_i,
   output logic                    entropy_req_o,
   output logic [CntWidth-1:0]     state_o
);

   localparam logic [CntWidth-1:0] Taps = CntWidth'(lfsr_taps(CntWidth));
   localparam int unsigned         UseW = $clog2(LfsrUsageThreshold + 1);

   logic [CntWidth-1:0] lfsr_q, lfsr_d;
   logic [UseW-1:0]     use_q;
   logic                reseed;

   assign entropy_req_o = (use_q >= UseW'(LfsrUsageThreshold));
   assign reseed        = entropy_req_o & entropy_ack_i;
   assign state_o       = lfsr_q;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : '0);
      end
      if (reseed) begin
         lfsr_d[EntropyWidth-1:0] = lfsr_d[EntropyWidth-1:0] ^ entropy_i;
      end
      // An all-zero state would lock the LFSR up for good.
      if (lfsr_d == '0) begin
         lfsr_d = LfsrSeed;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= LfsrSeed;
         use_q  <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         if (reseed) begin
            use_q <= '0;
         end else if (step_i && !entropy_req_o) begin
            use_q <= use_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/otp_ctrl_chk_sched.sv
// Round-robin scheduler for periodic/one-shot OTP partition checks; request issued 1 cycle after eligibility.
// A class holds its requests until every partition acks or the timeout expires; other classes wait.
module otp_ctrl_chk_sched
   import otp_ctrl_chk_sched_pkg::*;
#(
   parameter int unsigned         NumChk             = 2,
   parameter int unsigned         NumPart            = 8,
   parameter int unsigned         CntWidth           = 40,
   parameter int unsigned         MskWidth           = 32,
   parameter int unsigned         EntropyWidth       = 32,
   parameter int unsigned         LfsrUsageThreshold = 16,
   parameter logic [CntWidth-1:0] LfsrSeed           = CntWidth'(1),
   localparam int unsigned        ChkW               = (NumChk > 1) ? $clog2(NumChk) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        timer_en_i,
   output logic                        entropy_req_o,
   input  logic                        entropy_ack_i,
   input  logic [EntropyWidth-1:0]     entropy_i,
   input  logic [NumChk*MskWidth-1:0]  period_msk_i,
   input  logic [NumChk-1:0]           chk_trig_i,
   input  logic [NumChk-1:0]           pause_i,
   input  logic [31:0]                 timeout_i,
   output logic [NumChk*NumPart-1:0]   chk_req_o,
   input  logic [NumChk*NumPart-1:0]   chk_ack_i,
   input  logic                        escalate_i,
   output logic                        chk_pending_o,
   output logic [ChkW-1:0]             active_chk_o,
   output logic                        chk_timeout_o,
   output logic [ChkW-1:0]             timeout_chk_o,
   output logic                        fsm_err_o
);

   if (!cnt_width_legal(CntWidth) || MskWidth > CntWidth || EntropyWidth > CntWidth ||
       NumChk < 1 || NumChk > 8) begin : gen_param_err
      $fatal(1, "otp_ctrl_chk_sched: illegal parameterisation");
   end

   state_e                          state_q;
   logic [NumChk-1:0][CntWidth-1:0] cnt_q;
   logic [31:0]                     tcnt_q;
   logic [NumChk-1:0]               trig_q;
   logic [NumChk-1:0][NumPart-1:0]  req_q;
   logic [ChkW-1:0]                 rr_q, active_q, tout_chk_q;
   logic                            tout_q, err_q;

   logic [NumChk-1:0][NumPart-1:0]  ack;
   logic [NumChk-1:0][CntWidth-1:0] msk, draw;
   logic [NumChk-1:0]               elig, clr;
   logic                            gnt_vld, tout_hit, done, lfsr_step;
   logic [ChkW-1:0]                 gnt_idx, rr_nxt;
   logic [CntWidth-1:0]             lfsr_state;

   assign ack = chk_ack_i;

   always_comb begin
      msk  = '1;
      draw = '0;
      elig = '0;
      for (int c = 0; c < NumChk; c++) begin
         msk[c][CntWidth-1 -: MskWidth] = period_msk_i[c*MskWidth +: MskWidth];
         draw[c] = lfsr_state & msk[c];
         elig[c] = ((|period_msk_i[c*MskWidth +: MskWidth]) && (cnt_q[c] == '0)) || trig_q[c];
      end
   end

   // Lowest eligible class at or above rr_q wins; otherwise wrap to the lowest eligible class.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int c = NumChk - 1; c >= 0; c--) begin
         if (elig[c]) begin
            gnt_vld = 1'b1;
            gnt_idx = ChkW'(c);
         end
      end
      for (int c = NumChk - 1; c >= 0; c--) begin
         if (elig[c] && (ChkW'(c) >= rr_q)) begin
            gnt_idx = ChkW'(c);
         end
      end
      rr_nxt = (32'(gnt_idx) == NumChk - 1) ? '0 : gnt_idx + 1'b1;
   end

   assign tout_hit  = (timeout_i != '0) && (tcnt_q == '0);
   assign done      = (state_q == WaitSt) && !escalate_i && !tout_hit && (req_q[active_q] == '0);
   assign lfsr_step = ((state_q == ResetSt) && timer_en_i && !escalate_i) || done;

   always_comb begin
      clr = '0;
      for (int c = 0; c < NumChk; c++) begin
         clr[c] = (state_q == IdleSt) && !escalate_i && gnt_vld && (gnt_idx == ChkW'(c)) && trig_q[c];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ResetSt;
         cnt_q      <= '0;
         tcnt_q     <= '0;
         trig_q     <= '0;
         req_q      <= '0;
         rr_q       <= '0;
         active_q   <= '0;
         tout_chk_q <= '0;
         tout_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         trig_q <= (trig_q & ~clr) | chk_trig_i;
         for (int c = 0; c < NumChk; c++) begin
            if (state_q != ErrorSt) begin
               if (done && (active_q == ChkW'(c))) begin
                  cnt_q[c] <= draw[c];
               end else if (cnt_q[c] != '0) begin
                  cnt_q[c] <= cnt_q[c] - 1'b1;
               end
            end
         end
         if (escalate_i) begin
            state_q <= ErrorSt;
            err_q   <= 1'b1;
            req_q   <= '0;
            trig_q  <= '0;
         end else begin
            case (state_q)
               ResetSt: begin
                  if (timer_en_i) state_q <= IdleSt;
               end
               IdleSt: begin
                  if (gnt_vld) begin
                     state_q        <= WaitSt;
                     req_q[gnt_idx] <= '1;
                     tcnt_q         <= timeout_i;
                     rr_q           <= rr_nxt;
                     active_q       <= gnt_idx;
                  end
               end
               WaitSt: begin
                  req_q[active_q] <= req_q[active_q] & ~ack[active_q];
                  if ((tcnt_q != '0) && !pause_i[active_q]) begin
                     tcnt_q <= tcnt_q - 1'b1;
                  end
                  if (tout_hit) begin
                     state_q    <= ErrorSt;
                     tout_q     <= 1'b1;
                     tout_chk_q <= active_q;
                     req_q      <= '0;
                     trig_q     <= '0;
                  end else if (req_q[active_q] == '0) begin
                     state_q <= IdleSt;
                  end
               end
               ErrorSt: begin
                  req_q  <= '0;
                  trig_q <= '0;
               end
               default: begin
                  state_q <= ErrorSt;
                  err_q   <= 1'b1;
                  req_q   <= '0;
                  trig_q  <= '0;
               end
            endcase
         end
      end
   end

   otp_ctrl_chk_lfsr #(
      .CntWidth           (CntWidth),
      .EntropyWidth       (EntropyWidth),
      .LfsrUsageThreshold (LfsrUsageThreshold),
      .LfsrSeed           (LfsrSeed)
   ) u_lfsr (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .step_i        (lfsr_step),
      .entropy_ack_i (entropy_ack_i),
      .entropy_i     (entropy_i),
      .entropy_req_o (entropy_req_o),
      .state_o       (lfsr_state)
   );

   assign chk_req_o     = req_q;
   assign chk_pending_o = (state_q != ErrorSt) && ((|trig_q) || (state_q == WaitSt));
   assign active_chk_o  = active_q;
   assign chk_timeout_o = tout_q;
   assign timeout_chk_o = tout_chk_q;
   assign fsm_err_o     = err_q;

endmodule

// File: tb/tb_otp_ctrl_chk_sched.sv
// Directed bench for otp_ctrl_chk_sched (NumChk=2, NumPart=8, CntWidth=40); outputs sampled on the falling edge.
module tb_otp_ctrl_chk_sched;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        timer_en_i = 1'b0;
   logic        entropy_req_o;
   logic        entropy_ack_i = 1'b0;
   logic [31:0] entropy_i = '0;
   logic [63:0] period_msk_i = '0;
   logic [1:0]  chk_trig_i = '0;
   logic [1:0]  pause_i = '0;
   logic [31:0] timeout_i = '0;
   logic [15:0] chk_req_o;
   logic [15:0] chk_ack_i = '0;
   logic        escalate_i = 1'b0;
   logic        chk_pending_o;
   logic [0:0]  active_chk_o;
   logic        chk_timeout_o;
   logic [0:0]  timeout_chk_o;
   logic        fsm_err_o;

   int n_chk = 0;
   int n_err = 0;

   otp_ctrl_chk_sched dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .timer_en_i    (timer_en_i),
      .entropy_req_o (entropy_req_o),
      .entropy_ack_i (entropy_ack_i),
      .entropy_i     (entropy_i),
      .period_msk_i  (period_msk_i),
      .chk_trig_i    (chk_trig_i),
      .pause_i       (pause_i),
      .timeout_i     (timeout_i),
      .chk_req_o     (chk_req_o),
      .chk_ack_i     (chk_ack_i),
      .escalate_i    (escalate_i),
      .chk_pending_o (chk_pending_o),
      .active_chk_o  (active_chk_o),
      .chk_timeout_o (chk_timeout_o),
      .timeout_chk_o (timeout_chk_o),
      .fsm_err_o     (fsm_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] lfsr_nxt(input logic [39:0] s);
      return s[0] ? ((s >> 1) ^ 40'hA0_0014_0000) : (s >> 1);
   endfunction

   task automatic do_reset();
      rst_i         = 1'b1;
      timer_en_i    = 1'b0;
      entropy_ack_i = 1'b0;
      entropy_i     = '0;
      period_msk_i  = '0;
      chk_trig_i    = '0;
      pause_i       = '0;
      timeout_i     = '0;
      chk_ack_i     = '0;
      escalate_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      check_val("reset_outputs",
                {entropy_req_o, chk_pending_o, active_chk_o, chk_timeout_o, timeout_chk_o, fsm_err_o, chk_req_o},
                '0);
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic start();
      timer_en_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic pulse_trig(input logic [1:0] v);
      chk_trig_i = v;
      @(negedge clk_i);
      chk_trig_i = '0;
   endtask

   // Counts low-request samples (including the current one) until a request appears.
   task automatic wait_req(output int gap);
      gap = 0;
      while (chk_req_o == '0 && gap < 6000) begin
         @(negedge clk_i);
         gap++;
      end
      check_val("wait_req", chk_req_o != '0, 1);
   endtask

   task automatic ack_all();
      chk_ack_i = 16'hFFFF;
      @(negedge clk_i);
      chk_ack_i = '0;
   endtask

   initial begin
      int          gap, n, exp_gap;
      logic [15:0] exp_req;
      logic [39:0] m;

      // One-shot class 1, partitions acked one per cycle; stray class 0 acks are ignored.
      do_reset();
      start();
      pulse_trig(2'b10);
      check_val("t1_req_not_yet", chk_req_o, 16'h0000);
      @(negedge clk_i);
      check_val("t1_req_class1", chk_req_o, 16'hFF00);
      check_val("t1_active", active_chk_o, 1);
      exp_req = 16'hFF00;
      for (int b = 0; b < 8; b++) begin
         chk_ack_i = (16'h0100 << b) | 16'h0001;
         @(negedge clk_i);
         exp_req = exp_req & ~(16'h0100 << b);
         check_val("t1_partial_ack", chk_req_o, exp_req);
      end
      chk_ack_i = '0;
      check_val("t1_pending_wait", chk_pending_o, 1);
      @(negedge clk_i);
      check_val("t1_pending_idle", chk_pending_o, 0);

      // Both classes triggered together, twice: grants alternate 0,1,0,1.
      do_reset();
      start();
      pulse_trig(2'b11);
      for (int k = 0; k < 4; k++) begin
         wait_req(gap);
         check_val("t2_rr_req", chk_req_o, (k % 2) ? 16'hFF00 : 16'h00FF);
         check_val("t2_rr_active", active_chk_o, k % 2);
         ack_all();
         @(negedge clk_i);
         check_val("t2_pending", chk_pending_o, (k % 2) ? 0 : 1);
         if (k == 1) pulse_trig(2'b11);
      end

      // Timeout with no acks: 11 request cycles (counter 10..0), then ErrorSt.
      do_reset();
      timeout_i = 32'd10;
      start();
      pulse_trig(2'b01);
      wait_req(gap);
      n = 0;
      while (chk_req_o != '0 && n < 100) begin
         n++;
         @(negedge clk_i);
      end
      check_val("t3_req_cycles", n, 11);
      check_val("t3_timeout", chk_timeout_o, 1);
      check_val("t3_timeout_chk", timeout_chk_o, 0);
      check_val("t3_fsm_err", fsm_err_o, 0);
      check_val("t3_req_clr", chk_req_o, 0);
      check_val("t3_pending", chk_pending_o, 0);

      // Paused class 1 outlives the timeout, then completes normally.
      do_reset();
      timeout_i = 32'd10;
      pause_i   = 2'b10;
      start();
      pulse_trig(2'b10);
      wait_req(gap);
      repeat (20) @(negedge clk_i);
      check_val("t4_no_timeout", chk_timeout_o, 0);
      check_val("t4_req_held", chk_req_o, 16'hFF00);
      ack_all();
      @(negedge clk_i);
      pause_i = '0;
      check_val("t4_idle", chk_pending_o, 0);
      check_val("t4_no_timeout_end", chk_timeout_o, 0);
      check_val("t4_no_err", fsm_err_o, 0);

      // Periodic class 0: gaps follow the LFSR draws, reseed after 16 steps, entropy XORed in.
      do_reset();
      period_msk_i = {32'h0, 32'h0000_000F};
      m = 40'h1;
      start();
      m = lfsr_nxt(m);
      exp_gap = 0;
      for (int k = 1; k <= 18; k++) begin
         wait_req(gap);
         if (k >= 2) check_val("t5_period_gap", gap, exp_gap);
         check_val("t5_entropy_req", entropy_req_o, (k == 16 || k == 17) ? 1 : 0);
         check_val("t5_req_class0", chk_req_o, 16'h00FF);
         if (k == 17) begin
            entropy_i     = 32'hDEADBEEF;
            entropy_ack_i = 1'b1;
            @(negedge clk_i);
            entropy_ack_i = 1'b0;
            check_val("t5_entropy_req_drop", entropy_req_o, 0);
            m[31:0] = m[31:0] ^ 32'hDEADBEEF;
            if (m == '0) m = 40'h1;
         end
         exp_gap = int'(m & 40'hFFF) + 2;
         m = lfsr_nxt(m);
         ack_all();
      end

      // Escalation in WaitSt: ErrorSt next cycle, requests dropped, later triggers ignored.
      do_reset();
      start();
      pulse_trig(2'b01);
      wait_req(gap);
      escalate_i = 1'b1;
      @(negedge clk_i);
      escalate_i = 1'b0;
      check_val("t6_fsm_err", fsm_err_o, 1);
      check_val("t6_req_clr", chk_req_o, 0);
      check_val("t6_no_timeout", chk_timeout_o, 0);
      pulse_trig(2'b11);
      repeat (3) @(negedge clk_i);
      check_val("t6_trig_ignored", chk_req_o, 0);
      check_val("t6_pending", chk_pending_o, 0);

      // Asynchronous reset during an active request drops it within the cycle.
      do_reset();
      start();
      pulse_trig(2'b10);
      wait_req(gap);
      rst_i = 1'b1;
      #1;
      check_val("t7_async_reset", chk_req_o, 0);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
